// File: rtl/mtl_timing_pkg.sv
// mtl_timing_pkg: timing constants for the MTL 800x480 panel plus the sync bundle type
// shared by the scan generator and its delay line.
package mtl_timing_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  localparam logic [X_W-1:0] H_ACTIVE = 11'd800;
  localparam logic [X_W-1:0] H_FRONT  = 11'd210;
  localparam logic [X_W-1:0] H_SYNC   = 11'd30;
  localparam logic [X_W-1:0] H_BACK   = 11'd16;
  localparam logic [X_W-1:0] H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam logic [X_W-1:0] H_MAX    = H_TOTAL - 11'd1;
  localparam logic [X_W-1:0] HS_START = H_ACTIVE + H_FRONT;
  localparam logic [X_W-1:0] HS_END   = HS_START + H_SYNC - 11'd1;

  localparam logic [Y_W-1:0] V_ACTIVE = 10'd480;
  localparam logic [Y_W-1:0] V_FRONT  = 10'd22;
  localparam logic [Y_W-1:0] V_SYNC   = 10'd13;
  localparam logic [Y_W-1:0] V_BACK   = 10'd10;
  localparam logic [Y_W-1:0] V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [Y_W-1:0] V_MAX    = V_TOTAL - 10'd1;
  localparam logic [Y_W-1:0] VS_START = V_ACTIVE + V_FRONT;
  localparam logic [Y_W-1:0] VS_END   = VS_START + V_SYNC - 10'd1;

  localparam int PIPE_DLY_DEF = 2;

  // Syncs are carried in their active-low panel form so idle is simply all-ones except de.
  typedef struct packed {
    logic hsN;
    logic vsN;
    logic de;
  } sync_bus_t;

  localparam sync_bus_t SYNC_IDLE = '{hsN: 1'b1, vsN: 1'b1, de: 1'b0};

endpackage

// File: rtl/scan_delay_line.sv
// scan_delay_line: DEPTH-stage shift register with asynchronous reset to IDLE.
// DEPTH 0 degenerates to a plain wire from input to output.
module scan_delay_line #(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 1,
  parameter logic [WIDTH-1:0] IDLE  = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused;
    assign w_unused = i_clk ^ i_reset;
    assign o_data   = i_data;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shifts every cycle, independent of any scan enable, so idle values drain out naturally.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= IDLE;
      end else begin
        r_stage[0] <= i_data;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_data = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/mtl_scan_gen.sv
// mtl_scan_gen: raster scan counters and PIPE_DLY-aligned hsync/vsync/de for the MTL panel.
// Define MTL_SCAN_FRAME_CNT_EN to add the 16-bit o_frame_cnt output.
module mtl_scan_gen
  import mtl_timing_pkg::*;
#(
  parameter int PIPE_DLY = PIPE_DLY_DEF
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_enable,
  output logic [X_W-1:0] o_x_cnt,
  output logic [Y_W-1:0] o_y_cnt,
  output logic           o_frame_start,
  output logic           o_hsync_n,
  output logic           o_vsync_n,
`ifdef MTL_SCAN_FRAME_CNT_EN
  output logic [15:0]    o_frame_cnt,
`endif
  output logic           o_de
);

  logic [X_W-1:0] r_xCnt;
  logic [Y_W-1:0] r_yCnt;
  logic           r_frameStart;
  logic           w_xWrap;
  logic           w_yWrap;
  logic           w_frameSet;
  sync_bus_t      w_raw;
  sync_bus_t      w_dly;

  assign w_xWrap    = (r_xCnt == H_MAX);
  assign w_yWrap    = (r_yCnt == V_MAX);
  assign w_frameSet = i_enable && w_xWrap && w_yWrap;

  // Parking at the last position makes the first enabled edge land on (0,0) with a frame pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_xCnt <= H_MAX;
      r_yCnt <= V_MAX;
    end else if (i_enable) begin
      if (w_xWrap) begin
        r_xCnt <= '0;
        r_yCnt <= w_yWrap ? '0 : r_yCnt + Y_W'(1);
      end else begin
        r_xCnt <= r_xCnt + X_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_frameStart <= 1'b0;
    else         r_frameStart <= w_frameSet;
  end

  // Raw timing is forced idle while paused so the panel sees blanking during a hold.
  always_comb begin
    w_raw = SYNC_IDLE;
    if (i_enable) begin
      w_raw.de  = (r_xCnt < H_ACTIVE) && (r_yCnt < V_ACTIVE);
      w_raw.hsN = !((r_xCnt >= HS_START) && (r_xCnt <= HS_END));
      w_raw.vsN = !((r_yCnt >= VS_START) && (r_yCnt <= VS_END));
    end
  end

  scan_delay_line #(
    .WIDTH ($bits(sync_bus_t)),
    .DEPTH (PIPE_DLY),
    .IDLE  (SYNC_IDLE)
  ) u_delay (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_data  (w_raw),
    .o_data  (w_dly)
  );

`ifdef MTL_SCAN_FRAME_CNT_EN
  logic [15:0] r_frameCnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)         r_frameCnt <= '0;
    else if (w_frameSet) r_frameCnt <= r_frameCnt + 16'd1;
  end

  assign o_frame_cnt = r_frameCnt;
`endif

  assign o_x_cnt       = r_xCnt;
  assign o_y_cnt       = r_yCnt;
  assign o_frame_start = r_frameStart;
  assign o_hsync_n     = w_dly.hsN;
  assign o_vsync_n     = w_dly.vsN;
  assign o_de          = w_dly.de;

endmodule

// File: tb/tb_mtl_scan_gen.sv
// tb_mtl_scan_gen: random-enable scan against a linear-position reference model.
// Build with MTL_SCAN_FRAME_CNT_EN defined to also cover the frame counter.
module tb_mtl_scan_gen;

  localparam int HT    = 1056;
  localparam int VT    = 525;
  localparam int FRAME = HT * VT;
  localparam int DLY   = 2;
  localparam logic [2:0] IDLE = 3'b110;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [10:0] xCnt;
  logic [9:0]  yCnt;
  logic        frameStart;
  logic        hsyncN;
  logic        vsyncN;
  logic        de;
`ifdef MTL_SCAN_FRAME_CNT_EN
  logic [15:0] frameCnt;
`endif

  int         totalChecks = 0;
  int         badChecks   = 0;
  int         k;
  logic       lastEdgeEn;
  logic [2:0] hist[$];
  int         fcnt;

  always #5 clk = ~clk;

  mtl_scan_gen #(.PIPE_DLY(DLY)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_enable      (enable),
    .o_x_cnt       (xCnt),
    .o_y_cnt       (yCnt),
    .o_frame_start (frameStart),
    .o_hsync_n     (hsyncN),
    .o_vsync_n     (vsyncN),
`ifdef MTL_SCAN_FRAME_CNT_EN
    .o_frame_cnt   (frameCnt),
`endif
    .o_de          (de)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    totalChecks++;
    if (observed != expected) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0d want=%0d (model pos x=%0d y=%0d)", tag, observed, expected, k % HT, k / HT);
    end
  endtask

  // Panel timing straight from the line/frame geometry: {hsync_n, vsync_n, de}.
  function automatic logic [2:0] rawOf(input int kk, input logic en);
    int   x, y;
    logic d, h, v;
    x = kk % HT;
    y = kk / HT;
    d = en && (x < 800) && (y < 480);
    h = !(en && (x >= 1010) && (x <= 1039));
    v = !(en && (y >= 502) && (y <= 514));
    return {h, v, d};
  endfunction

  task automatic resetModel();
    k          = FRAME - 1;
    lastEdgeEn = 1'b0;
    fcnt       = 0;
    hist.delete();
  endtask

  task automatic checkCycle();
    logic [2:0] expSync;
    expSync = (hist.size() >= DLY) ? hist[hist.size()-DLY] : IDLE;
    checkOutput("x_cnt", int'(xCnt), k % HT);
    checkOutput("y_cnt", int'(yCnt), k / HT);
    checkOutput("frame_start", int'(frameStart), int'(lastEdgeEn && (k == 0)));
    checkOutput("hsync_n", int'(hsyncN), int'(expSync[2]));
    checkOutput("vsync_n", int'(vsyncN), int'(expSync[1]));
    checkOutput("de", int'(de), int'(expSync[0]));
`ifdef MTL_SCAN_FRAME_CNT_EN
    checkOutput("frame_cnt", int'(frameCnt), fcnt);
`endif
  endtask

  // One pixel cycle: check, drive enable, take the edge, advance the model.
  task automatic applyStimulus(input logic en);
    checkCycle();
    enable = en;
    hist.push_back(rawOf(k, en));
    if (hist.size() > 8) void'(hist.pop_front());
    @(posedge clk);
    lastEdgeEn = en;
    if (en) begin
      k = (k + 1) % FRAME;
      if (k == 0) fcnt = (fcnt + 1) % 65536;
    end
    @(negedge clk);
  endtask

  // Teleports the scan position so distant parts of the frame fit in a short run.
  task automatic jumpTo(input int x, input int y);
    force dut.r_xCnt = 11'(x);
    force dut.r_yCnt = 10'(y);
    #1;
    release dut.r_xCnt;
    release dut.r_yCnt;
    k = y * HT + x;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " x_cnt"}, int'(xCnt), 1055);
    checkOutput({tag, " y_cnt"}, int'(yCnt), 524);
    checkOutput({tag, " frame_start"}, int'(frameStart), 0);
    checkOutput({tag, " de"}, int'(de), 0);
    checkOutput({tag, " hsync_n"}, int'(hsyncN), 1);
    checkOutput({tag, " vsync_n"}, int'(vsyncN), 1);
`ifdef MTL_SCAN_FRAME_CNT_EN
    checkOutput({tag, " frame_cnt"}, int'(frameCnt), 0);
`endif
  endtask

  // Hard stop in case something upstream stalls the clock loop.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   prevK;
    logic wrapped;
    logic done;

    reset  = 1'b1;
    enable = 1'b0;
    resetModel();
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;

    $display("[TB] start-up");
    repeat (6) applyStimulus(1'b1);

    $display("[TB] random enable across the first lines");
    for (int i = 0; i < 2600; i++) applyStimulus(($urandom_range(0, 7) != 0));

    $display("[TB] pause at (400,100)");
    jumpTo(395, 100);
    for (int i = 0; i < 20 && k != 100 * HT + 400; i++) applyStimulus(1'b1);
    checkOutput("pause x", int'(xCnt), 400);
    checkOutput("pause y", int'(yCnt), 100);
    repeat (10) applyStimulus(1'b0);
    checkOutput("held x", int'(xCnt), 400);
    checkOutput("held de", int'(de), 0);
    applyStimulus(1'b1);
    checkOutput("resume x", int'(xCnt), 401);
    repeat (5) applyStimulus(1'b1);

    $display("[TB] vertical sync and frame wrap");
    jumpTo(1000, 500);
    wrapped = 1'b0;
    done    = 1'b0;
    for (int i = 0; i < 40000 && !done; i++) begin
      prevK = k;
      applyStimulus(($urandom_range(0, 9) != 0));
      if (k < prevK) wrapped = 1'b1;
      if (wrapped && k >= HT + 20) done = 1'b1;
    end
    checkOutput("frame wrap reached", int'(done), 1);

    $display("[TB] reset mid-frame at (600,300)");
    jumpTo(598, 300);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkCycle();
    reset = 1'b1;
    #1;
    checkResetValues("async reset");
    resetModel();
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) applyStimulus(1'b1);

`ifdef MTL_SCAN_FRAME_CNT_EN
    $display("[TB] frame counter wrap");
    jumpTo(1050, 524);
    force dut.r_frameCnt = 16'hFFFF;
    #1;
    release dut.r_frameCnt;
    fcnt = 65535;
    repeat (10) applyStimulus(1'b1);
    checkOutput("frame_cnt wrap", int'(frameCnt), 0);
`endif

    checkCycle();
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
